mode_sequencer: RTL and testbench
=================================

MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameter NUM_MODES, default 4: number of selectable modes; legal range 2..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before the filtered button level changes; minimum 1.
REQ-003 Parameter LONG_PRESS_CYCLES, default 2000: filtered-high cycles that qualify a press as long; must exceed DEBOUNCE_CYCLES.
REQ-004 Parameter TIMEOUT_CYCLES, default 10000: inactivity cycles before automatic return to mode 0; 0 disables the timeout.
REQ-005 Derived MODE_W = clog2(NUM_MODES), minimum 1.
REQ-006 ck  input  1  system clock; all state updates on its rising edge.
REQ-007 reset  input  1  reset, asynchronous, active-high.
REQ-008 mode  input  1  raw push-button level, asynchronous to ck, may bounce.
REQ-009 activity  input  1  level, already synchronous; high while any other user control is active.
REQ-010 mode_sel  output  MODE_W  registered current mode index.
REQ-011 mode_onehot  output  NUM_MODES  registered one-hot copy of mode_sel.
REQ-012 mode_changed  output  1  one-cycle pulse, asserted in the same cycle that mode_sel takes a new value.
REQ-013 long_press  output  1  one-cycle pulse when a press qualifies as long.

Function
REQ-014 mode passes through a 2-flop synchronizer; the filtered level db toggles only after the synchronized value has differed from db for DEBOUNCE_CYCLES consecutive cycles; any intermediate agreement restarts the count.
REQ-015 Press FSM states: RELEASED, PRESSED, LONG_HELD; only db drives transitions.
REQ-016 RELEASED -> PRESSED on db rise; the hold counter clears to 0.
REQ-017 PRESSED: the hold counter increments each cycle; when it reaches LONG_PRESS_CYCLES, go to LONG_HELD, pulse long_press, and set mode_sel to 0 (mode_changed only if the previous value was nonzero).
REQ-018 PRESSED -> RELEASED on db fall before the threshold (short press): mode_sel advances by 1 on the next edge, with mode_changed.
REQ-019 Wrap-around: a short press at NUM_MODES-1 sets mode_sel to 0.
REQ-020 LONG_HELD -> RELEASED on db fall with no mode change; the hold counter saturates while held.
REQ-021 Timeout counter clears whenever db=1, activity=1, or mode_sel=0; otherwise it increments; on reaching TIMEOUT_CYCLES it sets mode_sel to 0 with mode_changed and clears.
REQ-022 Simultaneous events: a short-press advance and timeout expiry cannot coincide because db=1 clears the timer; a long-press reset takes priority over any other update in the same cycle.
REQ-023 mode_onehot always equals 1 << mode_sel, with no lag.
REQ-024 Short-press latency: mode_sel updates on the first edge after the db fall is registered, 2 + DEBOUNCE_CYCLES + 1 cycles after a clean raw release.

Reset
REQ-025 While reset is high: mode_sel=0, mode_onehot=1, mode_changed=0, long_press=0, FSM=RELEASED, synchronizer/db/all counters=0.
REQ-026 Reset mid-press aborts the press with no mode change; a button still held after reset release is filtered and treated as a new press.

Structure
REQ-027 Package mode_seq_pkg shall hold the FSM state encodings and the clog2 function.
REQ-028 Synchronizer and debounce shall be one sub-module, button_debounce (params DEBOUNCE_CYCLES; ports ck, reset, raw, db).

Verification (bench params NUM_MODES=3, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, TIMEOUT_CYCLES=50)
REQ-029 Three clean short presses from reset -> mode_sel 1,2,0; onehot 010,100,001; one mode_changed pulse each.
REQ-030 Press with 3-cycle bounce glitches, then stable for 10 cycles, then release -> exactly one advance (0->1).
REQ-031 mode_sel=2, hold for 30 cycles -> long_press pulse once, mode_sel=0 at hold cycle 20; no change on release.
REQ-032 mode_sel=1, idle for 50 cycles -> mode_sel=0 with one mode_changed pulse; repeating with activity pulsed every 30 cycles -> mode_sel stays 1.
REQ-033 Assert reset while PRESSED at hold count 10 -> all outputs at reset values at once; a button still held afterwards yields a single advance on release.

Source files
------------

// File: rtl/mode_seq_pkg.sv
// Shared types and helpers for the mode sequencer: press FSM encoding and a
// constant ceil(log2) used to size counters and the mode index.
package mode_seq_pkg;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } press_state_t;

    // Never returns less than 1 so single-value ranges still get a real bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a stability filter: db only follows the
// synchronized level after it has disagreed with db for DEBOUNCE_CYCLES cycles.
module button_debounce
    import mode_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic ck,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_meta;
    logic             sync_stable;
    logic             db_reg;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            sync_meta   <= 1'b0;
            sync_stable <= 1'b0;
            db_reg      <= 1'b0;
            stable_cnt  <= '0;
        end else begin
            sync_meta   <= raw;
            sync_stable <= sync_meta;
            // Any cycle of agreement restarts the qualification window.
            if (sync_stable != db_reg) begin
                if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_reg     <= sync_stable;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    assign db = db_reg;

endmodule

// File: rtl/mode_sequencer.sv
// Single-button mode selector: short press advances the mode, long press and
// inactivity timeout return to mode 0. All outputs are registered.
module mode_sequencer
    import mode_seq_pkg::*;
#(
    parameter  int NUM_MODES         = 4,
    parameter  int DEBOUNCE_CYCLES   = 4,
    parameter  int LONG_PRESS_CYCLES = 2000,
    parameter  int TIMEOUT_CYCLES    = 10000,
    localparam int MODE_W            = clog2(NUM_MODES)
) (
    input  logic                 ck,
    input  logic                 reset,
    input  logic                 mode,
    input  logic                 activity,
    output logic [MODE_W-1:0]    mode_sel,
    output logic [NUM_MODES-1:0] mode_onehot,
    output logic                 mode_changed,
    output logic                 long_press
);

    localparam int HOLD_W = clog2(LONG_PRESS_CYCLES + 1);

    logic db;

    press_state_t         state_reg, state_next;
    logic [HOLD_W-1:0]    hold_reg, hold_next;
    logic                 hold_done;
    logic                 short_evt;
    logic                 long_evt;
    logic                 timeout_evt;
    logic [MODE_W-1:0]    mode_reg, mode_next;
    logic [NUM_MODES-1:0] onehot_reg;
    logic                 changed_reg;
    logic                 long_reg;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .ck   (ck),
        .reset(reset),
        .raw  (mode),
        .db   (db)
    );

    // Counter value on the cycle before it would reach the long threshold.
    assign hold_done = (hold_reg == HOLD_W'(LONG_PRESS_CYCLES - 1));

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_reg <= RELEASED;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        case (state_reg)
            RELEASED: begin
                if (db) begin
                    state_next = PRESSED;
                    hold_next  = '0;
                end
            end
            PRESSED: begin
                if (!db) begin
                    state_next = RELEASED;
                end else if (hold_done) begin
                    state_next = LONG_HELD;
                    hold_next  = HOLD_W'(LONG_PRESS_CYCLES);
                end else begin
                    hold_next = hold_reg + 1'b1;
                end
            end
            LONG_HELD: begin
                // Counter stays saturated until the button is let go.
                if (!db) begin
                    state_next = RELEASED;
                end
            end
            default: begin
                state_next = RELEASED;
            end
        endcase
    end

    always_comb begin
        short_evt = (state_reg == PRESSED) && !db;
        long_evt  = (state_reg == PRESSED) && db && hold_done;
        mode_next = mode_reg;
        if (long_evt) begin
            mode_next = '0;
        end else if (short_evt) begin
            mode_next = (mode_reg == MODE_W'(NUM_MODES - 1)) ? '0 : mode_reg + 1'b1;
        end else if (timeout_evt) begin
            mode_next = '0;
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign timeout_evt = 1'b0;
        end else begin : g_timeout
            localparam int TIMER_W = clog2(TIMEOUT_CYCLES + 1);

            logic [TIMER_W-1:0] timer_reg, timer_next;
            logic               expire;

            always_comb begin
                timer_next = timer_reg;
                expire     = 1'b0;
                if (db || activity || (mode_reg == '0)) begin
                    timer_next = '0;
                end else if (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    timer_next = '0;
                    expire     = 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            always_ff @(posedge ck or posedge reset) begin
                if (reset) begin
                    timer_reg <= '0;
                end else begin
                    timer_reg <= timer_next;
                end
            end

            assign timeout_evt = expire;
        end
    endgenerate

    // One-hot copy is built from mode_next so it never lags mode_sel.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            mode_reg    <= '0;
            onehot_reg  <= NUM_MODES'(1);
            changed_reg <= 1'b0;
            long_reg    <= 1'b0;
        end else begin
            mode_reg    <= mode_next;
            onehot_reg  <= NUM_MODES'(1) << mode_next;
            changed_reg <= (mode_next != mode_reg);
            long_reg    <= long_evt;
        end
    end

    assign mode_sel     = mode_reg;
    assign mode_onehot  = onehot_reg;
    assign mode_changed = changed_reg;
    assign long_press   = long_reg;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer with NUM_MODES=3, DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20, TIMEOUT_CYCLES=50.
module tb_mode_sequencer;

    logic       ck = 1'b0;
    logic       reset;
    logic       mode;
    logic       activity;
    logic [1:0] mode_sel;
    logic [2:0] mode_onehot;
    logic       mode_changed;
    logic       long_press;

    int checks = 0;
    int errors = 0;
    int changed_cnt = 0;
    int long_cnt = 0;

    mode_sequencer #(
        .NUM_MODES        (3),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .TIMEOUT_CYCLES   (50)
    ) dut (
        .ck          (ck),
        .reset       (reset),
        .mode        (mode),
        .activity    (activity),
        .mode_sel    (mode_sel),
        .mode_onehot (mode_onehot),
        .mode_changed(mode_changed),
        .long_press  (long_press)
    );

    always #5 ck = ~ck;

    // Pulse tallies, sampled shortly after each rising edge.
    always @(posedge ck) begin
        #2;
        if (mode_changed === 1'b1) changed_cnt++;
        if (long_press === 1'b1) long_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ck);
    endtask

    // Raw release, then the advance lands exactly 7 edges later.
    task automatic release_and_check(input string tag, input int exp_mode);
        int c0;
        c0 = changed_cnt;
        mode = 1'b0;
        tick(6);
        check({tag, " no_early_change"}, 32'(mode_changed), 32'd0);
        tick(1);
        check({tag, " mode_sel"}, 32'(mode_sel), 32'(exp_mode));
        check({tag, " onehot"}, 32'(mode_onehot), 32'd1 << exp_mode);
        check({tag, " changed_pulse"}, 32'(mode_changed), 32'd1);
        tick(1);
        check({tag, " changed_drop"}, 32'(mode_changed), 32'd0);
        check({tag, " changed_count"}, 32'(changed_cnt - c0), 32'd1);
        $display("press %s: mode_sel=%0d onehot=%b", tag, mode_sel, mode_onehot);
    endtask

    task automatic short_press(input string tag, input int hold, input int exp_mode);
        mode = 1'b1;
        tick(hold);
        release_and_check(tag, exp_mode);
    endtask

    initial begin
        int c0;
        int l0;
        reset = 1'b1;
        mode = 1'b0;
        activity = 1'b0;
        tick(2);
        check("reset mode_sel", 32'(mode_sel), 32'd0);
        check("reset onehot", 32'(mode_onehot), 32'd1);
        check("reset changed", 32'(mode_changed), 32'd0);
        check("reset long", 32'(long_press), 32'd0);
        reset = 1'b0;
        tick(3);

        // Three clean short presses wrap through all modes.
        short_press("short1", 10, 1);
        short_press("short2", 10, 2);
        short_press("short3_wrap", 10, 0);
        tick(3);

        // Bouncy press: single-cycle glitches must not qualify.
        c0 = changed_cnt;
        for (int i = 0; i < 3; i++) begin
            mode = 1'b1;
            tick(1);
            mode = 1'b0;
            tick(1);
        end
        tick(8);
        check("bounce no_change mode_sel", 32'(mode_sel), 32'd0);
        check("bounce no_change count", 32'(changed_cnt - c0), 32'd0);
        short_press("bounce", 10, 1);
        tick(10);
        check("bounce single_advance", 32'(changed_cnt - c0), 32'd1);

        // Long press from mode 2.
        short_press("to_mode2", 10, 2);
        c0 = changed_cnt;
        l0 = long_cnt;
        mode = 1'b1;
        tick(26);
        check("long before mode_sel", 32'(mode_sel), 32'd2);
        check("long before pulse", 32'(long_press), 32'd0);
        tick(1);
        check("long pulse", 32'(long_press), 32'd1);
        check("long mode_sel", 32'(mode_sel), 32'd0);
        check("long onehot", 32'(mode_onehot), 32'd1);
        check("long changed", 32'(mode_changed), 32'd1);
        tick(1);
        check("long pulse_drop", 32'(long_press), 32'd0);
        check("long changed_drop", 32'(mode_changed), 32'd0);
        tick(2);
        mode = 1'b0;
        tick(12);
        check("long release mode_sel", 32'(mode_sel), 32'd0);
        check("long changed_count", 32'(changed_cnt - c0), 32'd1);
        check("long pulse_count", 32'(long_cnt - l0), 32'd1);
        $display("long press: mode_sel=%0d long pulses=%0d", mode_sel, long_cnt - l0);

        // Inactivity timeout.
        short_press("to_mode1_timeout", 10, 1);
        c0 = changed_cnt;
        tick(48);
        check("timeout before", 32'(mode_sel), 32'd1);
        tick(1);
        check("timeout mode_sel", 32'(mode_sel), 32'd0);
        check("timeout changed", 32'(mode_changed), 32'd1);
        check("timeout changed_count", 32'(changed_cnt - c0), 32'd1);
        $display("timeout: mode_sel=%0d", mode_sel);

        // Periodic activity keeps the timer from expiring.
        short_press("to_mode1_activity", 10, 1);
        c0 = changed_cnt;
        for (int i = 0; i < 4; i++) begin
            tick(29);
            activity = 1'b1;
            tick(1);
            activity = 1'b0;
        end
        check("activity hold mode_sel", 32'(mode_sel), 32'd1);
        check("activity changed_count", 32'(changed_cnt - c0), 32'd0);
        $display("activity: mode_sel=%0d", mode_sel);

        // Reset in the middle of a press, button still held afterwards.
        mode = 1'b1;
        tick(17);
        reset = 1'b1;
        #1;
        check("midpress reset mode_sel", 32'(mode_sel), 32'd0);
        check("midpress reset onehot", 32'(mode_onehot), 32'd1);
        check("midpress reset changed", 32'(mode_changed), 32'd0);
        check("midpress reset long", 32'(long_press), 32'd0);
        tick(2);
        reset = 1'b0;
        c0 = changed_cnt;
        tick(10);
        check("after reset held mode_sel", 32'(mode_sel), 32'd0);
        release_and_check("after_reset", 1);
        tick(5);
        check("after reset changed_count", 32'(changed_cnt - c0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
